// File: rtl/axi_uart_fifo_regs.sv
// AXI4-Lite register block for the UART: CTRL, W1C STATUS, RX pop port and TX push port,
// with independent circular TX/RX FIFOs in front of the serial cores.
// Optional build macro UART_IRQ_EN adds irq_o and the CTRL[3:2] interrupt enables.
// Note: s_axi_aresetn_i is a synchronous, active-high reset despite its name.
`timescale 1ns / 1ps

module axi_uart_fifo_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter logic [31:0] ADDR_MASK = 32'h0000_000F,
    parameter int unsigned TX_DEPTH  = 32,
    parameter int unsigned RX_DEPTH  = 32
) (
    input  logic        s_axi_aclk_i,
    input  logic        s_axi_aresetn_i,
    input  logic [31:0] s_axi_araddr_i,
    input  logic        s_axi_arvalid_i,
    output logic        s_axi_arready_o,
    output logic [31:0] s_axi_rdata_o,
    output logic        s_axi_rvalid_o,
    input  logic        s_axi_rready_i,
    input  logic [31:0] s_axi_awaddr_i,
    input  logic        s_axi_awvalid_i,
    output logic        s_axi_awready_o,
    input  logic [31:0] s_axi_wdata_i,
    input  logic        s_axi_wvalid_i,
    output logic        s_axi_wready_o,
    output logic        s_axi_bvalid_o,
    input  logic        s_axi_bready_i,
    input  logic        t_done_i,
    input  logic        r_done_i,
    input  logic [7:0]  rx_i,
    output logic [7:0]  tx_o,
    output logic        tx_en_o,
    output logic        rx_en_o,
    output logic [15:0] baud_div_o
`ifdef UART_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned TxCw = TxAw + 1;
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned RxCw = RxAw + 1;

`ifdef UART_IRQ_EN
    localparam logic [31:0] CtrlMask = 32'hFFFF_000F;
`else
    localparam logic [31:0] CtrlMask = 32'hFFFF_0003;
`endif

    typedef enum logic {RdIdle, RdData} rd_state_e;
    typedef enum logic {WrIdle, WrResp} wr_state_e;

    logic rst;
    assign rst = s_axi_aresetn_i;

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;

    logic        ar_match, aw_match, ar_hs, wr_hs;
    logic [31:0] rdata_q, rd_mux, status;
    logic [31:0] ctrl_q;
    logic        ctrl_we, stat_we, wdata_we;

    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TxAw-1:0] tx_wr_q, tx_rd_q;
    logic [TxCw-1:0] tx_cnt_q;
    logic            tx_full, tx_empty, tx_push, tx_pop, tx_ovf_q;

    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RxAw-1:0] rx_wr_q, rx_rd_q;
    logic [RxCw-1:0] rx_cnt_q;
    logic            rx_full, rx_empty, rx_push, rx_pop, rx_push_req, rx_ovf_q;

    assign ar_match = (s_axi_araddr_i & ~ADDR_MASK) == BASE_ADDR;
    assign aw_match = (s_axi_awaddr_i & ~ADDR_MASK) == BASE_ADDR;
    assign ar_hs    = s_axi_arvalid_i & s_axi_arready_o;
    assign wr_hs    = s_axi_awready_o;

    // ---------------- read channel ----------------

    // Read FSM state register
    always_ff @(posedge s_axi_aclk_i) begin
        if (rst) rd_state_q <= RdIdle;
        else     rd_state_q <= rd_state_d;
    end

    // Read FSM next state: one transaction in flight at a time
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RdIdle:  if (s_axi_arvalid_i && ar_match) rd_state_d = RdData;
            RdData:  if (s_axi_rready_i) rd_state_d = RdIdle;
            default: rd_state_d = RdIdle;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        s_axi_arready_o = 1'b0;
        s_axi_rvalid_o  = 1'b0;
        case (rd_state_q)
            RdIdle:  s_axi_arready_o = s_axi_arvalid_i & ar_match & ~rst;
            RdData:  s_axi_rvalid_o  = 1'b1;
            default: ;
        endcase
    end

    // Status word assembled from live FIFO state
    always_comb begin
        status        = 32'h0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[4]     = rx_ovf_q;
        status[5]     = tx_ovf_q;
        status[15:8]  = 8'(rx_cnt_q);
        status[23:16] = 8'(tx_cnt_q);
    end

    // Read data select; RDATA on an empty FIFO and write-only/unmapped offsets read 0
    always_comb begin
        rd_mux = 32'h0;
        case (s_axi_araddr_i[3:2])
            2'd0:    rd_mux = ctrl_q;
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_q]};
            default: rd_mux = 32'h0;
        endcase
    end

    // Capture read data at address accept, held until rready
    always_ff @(posedge s_axi_aclk_i) begin
        if (rst)        rdata_q <= 32'h0;
        else if (ar_hs) rdata_q <= rd_mux;
    end
    assign s_axi_rdata_o = rdata_q;

    // ---------------- write channel ----------------

    // Write FSM state register
    always_ff @(posedge s_axi_aclk_i) begin
        if (rst) wr_state_q <= WrIdle;
        else     wr_state_q <= wr_state_d;
    end

    // Write FSM next state: address and data must arrive together
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WrIdle:  if (s_axi_awvalid_i && s_axi_wvalid_i && aw_match) wr_state_d = WrResp;
            WrResp:  if (s_axi_bready_i) wr_state_d = WrIdle;
            default: wr_state_d = WrIdle;
        endcase
    end

    // Write FSM outputs
    always_comb begin
        s_axi_awready_o = 1'b0;
        s_axi_wready_o  = 1'b0;
        s_axi_bvalid_o  = 1'b0;
        case (wr_state_q)
            WrIdle: begin
                s_axi_awready_o = s_axi_awvalid_i & s_axi_wvalid_i & aw_match & ~rst;
                s_axi_wready_o  = s_axi_awvalid_i & s_axi_wvalid_i & aw_match & ~rst;
            end
            WrResp:  s_axi_bvalid_o = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_we  = wr_hs && (s_axi_awaddr_i[3:2] == 2'd0);
    assign stat_we  = wr_hs && (s_axi_awaddr_i[3:2] == 2'd1);
    assign wdata_we = wr_hs && (s_axi_awaddr_i[3:2] == 2'd3);

    // CTRL register; unimplemented bits are masked so they read back 0
    always_ff @(posedge s_axi_aclk_i) begin
        if (rst)          ctrl_q <= 32'h0;
        else if (ctrl_we) ctrl_q <= s_axi_wdata_i & CtrlMask;
    end

    assign rx_en_o    = ctrl_q[1];
    assign baud_div_o = ctrl_q[31:16];

    // ---------------- TX FIFO ----------------

    assign tx_full  = tx_cnt_q == TxCw'(TX_DEPTH);
    assign tx_empty = tx_cnt_q == '0;
    assign tx_push  = wdata_we & ~tx_full;
    assign tx_en_o  = ctrl_q[0] & ~tx_empty;
    assign tx_pop   = t_done_i & tx_en_o;
    // Empty FIFO presents 0 rather than stale storage
    assign tx_o     = tx_empty ? 8'h0 : tx_mem[tx_rd_q];

    // TX storage write
    always_ff @(posedge s_axi_aclk_i) begin
        if (tx_push) tx_mem[tx_wr_q] <= s_axi_wdata_i[7:0];
    end

    // TX pointers, count and sticky overflow (set beats W1C)
    always_ff @(posedge s_axi_aclk_i) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + TxAw'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TxAw'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + TxCw'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - TxCw'(1);
            tx_ovf_q <= (tx_ovf_q & ~(stat_we & s_axi_wdata_i[5])) | (wdata_we & tx_full);
        end
    end

    // ---------------- RX FIFO ----------------

    assign rx_full     = rx_cnt_q == RxCw'(RX_DEPTH);
    assign rx_empty    = rx_cnt_q == '0;
    assign rx_push_req = r_done_i & ctrl_q[1];
    assign rx_push     = rx_push_req & ~rx_full;
    assign rx_pop      = ar_hs && (s_axi_araddr_i[3:2] == 2'd2) && !rx_empty;

    // RX storage write
    always_ff @(posedge s_axi_aclk_i) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_i;
    end

    // RX pointers, count and sticky overflow (set beats W1C)
    always_ff @(posedge s_axi_aclk_i) begin
        if (rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            rx_ovf_q <= 1'b0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + RxAw'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + RxAw'(1);
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + RxCw'(1);
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - RxCw'(1);
            rx_ovf_q <= (rx_ovf_q & ~(stat_we & s_axi_wdata_i[4])) | (rx_push_req & rx_full);
        end
    end

`ifdef UART_IRQ_EN
    logic irq_q;

    // Interrupt: RX data waiting, TX drained, or any sticky overflow
    always_ff @(posedge s_axi_aclk_i) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty) | rx_ovf_q | tx_ovf_q;
    end
    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_axi_uart_fifo_regs.sv
// Self-checking bench for axi_uart_fifo_regs with small FIFOs (TX 8, RX 4).
`timescale 1ns / 1ps

module tb_axi_uart_fifo_regs;

    localparam int unsigned TXD  = 8;
    localparam int unsigned RXD  = 4;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        t_done, r_done, tx_en, rx_en;
    logic [7:0]  rx, tx;
    logic [15:0] baud_div;
`ifdef UART_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    always #5 clk = ~clk;

    axi_uart_fifo_regs #(
        .BASE_ADDR(BASE),
        .ADDR_MASK(32'h0000_000F),
        .TX_DEPTH (TXD),
        .RX_DEPTH (RXD)
    ) dut (
        .s_axi_aclk_i   (clk),
        .s_axi_aresetn_i(rst),
        .s_axi_araddr_i (araddr),
        .s_axi_arvalid_i(arvalid),
        .s_axi_arready_o(arready),
        .s_axi_rdata_o  (rdata),
        .s_axi_rvalid_o (rvalid),
        .s_axi_rready_i (rready),
        .s_axi_awaddr_i (awaddr),
        .s_axi_awvalid_i(awvalid),
        .s_axi_awready_o(awready),
        .s_axi_wdata_i  (wdata),
        .s_axi_wvalid_i (wvalid),
        .s_axi_wready_o (wready),
        .s_axi_bvalid_o (bvalid),
        .s_axi_bready_i (bready),
        .t_done_i       (t_done),
        .r_done_i       (r_done),
        .rx_i           (rx),
        .tx_o           (tx),
        .tx_en_o        (tx_en),
        .rx_en_o        (rx_en),
        .baud_div_o     (baud_div)
`ifdef UART_IRQ_EN
        ,
        .irq_o          (irq)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        data    = 32'hxxxx_xxxx;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL read_ar_timeout: addr %h arready=%b required 1", addr, arready);
            arvalid = 1'b0;
            rready  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL read_r_timeout: addr %h rvalid=%b required 1", addr, rvalid);
        end else begin
            data = rdata;
        end
        tick();
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(awready && wready)) begin
            checks++; errors++;
            $display("FAIL write_aw_timeout: addr %h awready=%b wready=%b required 1",
                     addr, awready, wready);
            awvalid = 1'b0;
            wvalid  = 1'b0;
            bready  = 1'b0;
            return;
        end
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL write_b_timeout: addr %h bvalid=%b required 1", addr, bvalid);
        end
        tick();
        bready = 1'b0;
    endtask

    task automatic pulse_tdone();
        t_done = 1'b1;
        tick();
        t_done = 1'b0;
    endtask

    task automatic pulse_rdone(input logic [7:0] b);
        rx     = b;
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
    endtask

    // RDATA read whose address accept coincides with an r_done_i push
    task automatic read_rdata_with_push(input logic [7:0] b, output logic [31:0] data);
        data    = 32'hxxxx_xxxx;
        araddr  = BASE + 32'h8;
        arvalid = 1'b1;
        rready  = 1'b1;
        rx      = b;
        r_done  = 1'b1;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_arready: arready=%b required 1", arready);
        end
        tick();
        arvalid = 1'b0;
        r_done  = 1'b0;
        @(negedge clk);
        if (rvalid === 1'b1) data = rdata;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        t_done = 1'b0; r_done = 1'b0; rx = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({arready, rvalid, awready, wready, bvalid} !== 5'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_axi: ar/r/aw/w/b=%b rdata=%h required 0",
                     {arready, rvalid, awready, wready, bvalid}, rdata);
        end
        checks++;
        if (tx !== 8'h0 || tx_en !== 1'b0 || rx_en !== 1'b0 || baud_div !== 16'h0) begin
            errors++;
            $display("FAIL reset_uart: tx=%h tx_en=%b rx_en=%b baud=%h required 0",
                     tx, tx_en, rx_en, baud_div);
        end
`ifdef UART_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: irq=%b required 0", irq);
        end
`endif
        // STATUS read with arvalid held past accept and rready delayed
        exp_q.push_back(32'h0000_000A);
        araddr  = BASE + 32'h4;
        arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_arready_hi: arready=%b required 1", arready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (arready !== 1'b0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_arready_pulse: arready=%b rvalid=%b required 0/1",
                     arready, rvalid);
        end
        tick();
        arvalid = 1'b0;
        repeat (2) tick();
        e = exp_q.pop_front();
        checks++;
        if (rvalid !== 1'b1 || rdata !== e) begin
            errors++;
            $display("FAIL reset_status_hold: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, e);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid_drop: rvalid=%b required 0", rvalid);
        end
        exp_q.push_back(32'h0);
        axi_read(BASE + 32'h0, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL reset_ctrl: rdata=%h required %h", d, e);
        end
    endtask

    task automatic test_tx();
        logic [31:0] d, e;
        logic [7:0]  b;
        for (int i = 0; i < 3; i++) begin
            b = 8'h41 + 8'(i);
            axi_write(BASE + 32'hC, {24'h0, b});
            tx_q.push_back(b);
        end
        checks++;
        if (tx_en !== 1'b0) begin
            errors++;
            $display("FAIL tx_en_off: tx_en=%b required 0", tx_en);
        end
        exp_q.push_back(32'h0003_0008);
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL tx_status3: rdata=%h required %h", d, e);
        end
        axi_write(BASE + 32'h0, 32'h0001_0001);
        checks++;
        if (baud_div !== 16'h0001) begin
            errors++;
            $display("FAIL tx_baud: baud=%h required 0001", baud_div);
        end
        for (int i = 0; i < 3; i++) begin
            b = tx_q.pop_front();
            checks++;
            if (tx_en !== 1'b1 || tx !== b) begin
                errors++;
                $display("FAIL tx_head%0d: tx_en=%b tx=%h required 1/%h", i, tx_en, tx, b);
            end
            pulse_tdone();
        end
        checks++;
        if (tx_en !== 1'b0 || tx !== 8'h0) begin
            errors++;
            $display("FAIL tx_drained: tx_en=%b tx=%h required 0/00", tx_en, tx);
        end
        pulse_tdone();
        exp_q.push_back(32'h0000_000A);
        exp_q.push_back(32'h0001_0001);
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL tx_status_empty: rdata=%h required %h", d, e);
        end
        axi_read(BASE + 32'h0, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL tx_ctrl_kept: rdata=%h required %h", d, e);
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d, e;
        logic [7:0]  b;
        axi_write(BASE + 32'h0, 32'h0);
        for (int i = 0; i <= TXD; i++) begin
            b = 8'h10 + 8'(i);
            axi_write(BASE + 32'hC, {24'h0, b});
            if (tx_q.size() < TXD) tx_q.push_back(b);
        end
        exp_q.push_back(32'h0000_0029 | (32'(TXD) << 16));
        exp_q.push_back(32'h0000_0009 | (32'(TXD) << 16));
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL txovf_status: rdata=%h required %h", d, e);
        end
        axi_write(BASE + 32'h4, 32'h0000_0020);
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL txovf_w1c: rdata=%h required %h", d, e);
        end
        axi_write(BASE + 32'h0, 32'h0000_0001);
        for (int i = 0; i < TXD; i++) begin
            b = tx_q.pop_front();
            checks++;
            if (tx_en !== 1'b1 || tx !== b) begin
                errors++;
                $display("FAIL txovf_drain%0d: tx_en=%b tx=%h required 1/%h", i, tx_en, tx, b);
            end
            pulse_tdone();
        end
        checks++;
        if (tx_en !== 1'b0) begin
            errors++;
            $display("FAIL txovf_empty: tx_en=%b required 0", tx_en);
        end
        axi_write(BASE + 32'h0, 32'h0);
    endtask

    task automatic test_rx();
        logic [31:0] d, e;
        pulse_rdone(8'hEE);
        axi_write(BASE + 32'h0, 32'h0000_0002);
        checks++;
        if (rx_en !== 1'b1) begin
            errors++;
            $display("FAIL rx_en: rx_en=%b required 1", rx_en);
        end
        exp_q.push_back(32'h0000_000A);
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rx_disabled_ignored: rdata=%h required %h", d, e);
        end
        for (int i = 0; i < RXD + 2; i++) begin
            pulse_rdone(8'(i));
            if (rx_q.size() < RXD) rx_q.push_back(8'(i));
        end
        exp_q.push_back(32'h0000_0016 | (32'(RXD) << 8));
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rx_full_status: rdata=%h required %h", d, e);
        end
        while (rx_q.size() > 0) exp_q.push_back({24'h0, rx_q.pop_front()});
        exp_q.push_back(32'h0);
        for (int i = 0; i <= RXD; i++) begin
            axi_read(BASE + 32'h8, d);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL rx_pop%0d: rdata=%h required %h", i, d, e);
            end
        end
        exp_q.push_back(32'h0000_001A);
        exp_q.push_back(32'h0000_000A);
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rx_empty_status: rdata=%h required %h", d, e);
        end
        axi_write(BASE + 32'h4, 32'h0000_0010);
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rx_w1c: rdata=%h required %h", d, e);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d, e;
        pulse_rdone(8'h55);
        exp_q.push_back(32'h0000_0055);
        exp_q.push_back(32'h0000_0102);
        exp_q.push_back(32'h0000_0077);
        read_rdata_with_push(8'h77, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL same_pop_push_data: rdata=%h required %h", d, e);
        end
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL same_pop_push_count: rdata=%h required %h", d, e);
        end
        axi_read(BASE + 32'h8, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL same_retained: rdata=%h required %h", d, e);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_0102);
        exp_q.push_back(32'h0000_0099);
        read_rdata_with_push(8'h99, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL empty_pop_push_data: rdata=%h required %h", d, e);
        end
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL empty_pop_push_count: rdata=%h required %h", d, e);
        end
        axi_read(BASE + 32'h8, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL empty_push_kept: rdata=%h required %h", d, e);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d, e;
        logic        seen;
        seen    = 1'b0;
        araddr  = 32'h2000_0014;
        arvalid = 1'b1;
        rready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (arready !== 1'b0) seen = 1'b1;
            tick();
        end
        arvalid = 1'b0;
        rready  = 1'b0;
        checks++;
        if (seen || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_accepted: arready_seen=%b rvalid=%b required 0/0", seen, rvalid);
        end
        exp_q.push_back(32'h0);
        axi_read(BASE + 32'hC, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL wdata_read: rdata=%h required %h", d, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        axi_write(BASE + 32'h0, 32'h0005_0002);
        pulse_rdone(8'h12);
        axi_write(BASE + 32'hC, 32'h0000_00AB);
        awaddr  = BASE + 32'hC;
        wdata   = 32'h0000_00CD;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b0;
        @(negedge clk);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_bvalid_pending: bvalid=%b required 1", bvalid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_bvalid_drop: bvalid=%b required 0", bvalid);
        end
        rst = 1'b0;
        checks++;
        if (tx_en !== 1'b0 || rx_en !== 1'b0 || baud_div !== 16'h0 || tx !== 8'h0) begin
            errors++;
            $display("FAIL mid_outputs: tx_en=%b rx_en=%b baud=%h tx=%h required 0",
                     tx_en, rx_en, baud_div, tx);
        end
        exp_q.push_back(32'h0000_000A);
        axi_read(BASE + 32'h4, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL mid_status: rdata=%h required %h", d, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx();
        test_tx_overflow();
        test_rx();
        test_same_cycle();
        test_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
